// File: rtl/bp_pkg.sv
// Shared definitions for the branch prediction unit.
//   - default geometry of the branch target buffer (16 entries, 2-bit counters, 32-bit PC)
//   - bp_entry_t : one BTB entry {valid, tag, ctr, target} at the default geometry
//   - idx_of / tag_of : PC address split, usable at any geometry up to BP_PC_MAX bits
//   - weak_taken / weak_not_taken : counter reset/allocate values for any counter width
package bp_pkg;

  localparam int unsigned BP_PC_MAX  = 64;
  localparam int unsigned BP_XLEN    = 32;
  localparam int unsigned BP_ENTRIES = 16;
  localparam int unsigned BP_CTR_W   = 2;
  localparam int unsigned BP_IDX_W   = $clog2(BP_ENTRIES);
  localparam int unsigned BP_TAG_W   = BP_XLEN - BP_IDX_W - 2;

  // Counter values for the default width: MSB-only set is weakly taken,
  // one below that is weakly not-taken.
  localparam logic [BP_CTR_W-1:0] BP_WEAK_TAKEN     = BP_CTR_W'(1) << (BP_CTR_W - 1);
  localparam logic [BP_CTR_W-1:0] BP_WEAK_NOT_TAKEN = BP_WEAK_TAKEN - BP_CTR_W'(1);

  typedef struct packed {
    logic                valid;
    logic [BP_TAG_W-1:0] tag;
    logic [BP_CTR_W-1:0] ctr;
    logic [BP_XLEN-1:0]  target;
  } bp_entry_t;

  // Table index: word-aligned PC bits just above the byte offset.
  function automatic logic [BP_PC_MAX-1:0] idx_of(input logic [BP_PC_MAX-1:0] pc,
                                                  input int unsigned          idx_w);
    logic [BP_PC_MAX-1:0] mask;
    mask = (BP_PC_MAX'(1) << idx_w) - BP_PC_MAX'(1);
    return (pc >> 2) & mask;
  endfunction

  // Tag: every PC bit above the index.
  function automatic logic [BP_PC_MAX-1:0] tag_of(input logic [BP_PC_MAX-1:0] pc,
                                                  input int unsigned          idx_w);
    return pc >> (idx_w + 2);
  endfunction

  function automatic logic [31:0] weak_taken(input int unsigned ctr_w);
    return 32'd1 << (ctr_w - 1);
  endfunction

  function automatic logic [31:0] weak_not_taken(input int unsigned ctr_w);
    return weak_taken(ctr_w) - 32'd1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up/down direction counter, next-value logic only.
// Ports:
//   i_ctr      : current counter value
//   inc / dec  : step up (stops at all-ones) / step down (stops at zero)
//   load       : replace with i_load_val; has priority over inc/dec
//   i_load_val : value used on load
//   o_next_c   : combinational next value
module sat_counter #(
  parameter int unsigned CTR_W = 2
) (
  input  logic [CTR_W-1:0] i_ctr,
  input  logic             inc,
  input  logic             dec,
  input  logic             load,
  input  logic [CTR_W-1:0] i_load_val,
  output logic [CTR_W-1:0] o_next_c
);

  localparam logic [CTR_W-1:0] CTR_MAX = '1;
  localparam logic [CTR_W-1:0] CTR_MIN = '0;

  // Next counter value with saturation at both ends.
  always_comb begin
    o_next_c = i_ctr;
    if (load) begin
      o_next_c = i_load_val;
    end else if (inc) begin
      if (i_ctr != CTR_MAX) o_next_c = i_ctr + CTR_W'(1);
    end else if (dec) begin
      if (i_ctr != CTR_MIN) o_next_c = i_ctr - CTR_W'(1);
    end
  end

endmodule

// File: rtl/bht_predictor.sv
// Direct-mapped branch target buffer with saturating direction counters.
// Predicts combinationally for the fetch PC, trains from the EX stage on the
// rising edge, flags mispredictions and keeps saturating statistics.
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   if_pc                     : fetch PC to predict for
//   pred_taken, pred_target   : prediction (target is if_pc+4 when not taken)
//   ex_valid .. ex_pred_target: resolved EX instruction and its carried prediction
//   mispredict                : redirect request, combinational from the EX inputs
//   branch_cnt, mispred_cnt   : resolved-branch / misprediction counts
//   dbg_idx, dbg_entry        : debug read of one entry {valid @31, ctr @CTR_W-1:0}
module bht_predictor
  import bp_pkg::*;
#(
  parameter int unsigned ENTRIES = BP_ENTRIES,
  parameter int unsigned CTR_W   = BP_CTR_W,
  parameter int unsigned XLEN    = BP_XLEN,
  parameter int unsigned IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  if_pc,
  output logic             pred_taken,
  output logic [XLEN-1:0]  pred_target,
  input  logic             ex_valid,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic             ex_is_branch,
  input  logic             ex_taken,
  input  logic [XLEN-1:0]  ex_target,
  input  logic             ex_pred_taken,
  input  logic [XLEN-1:0]  ex_pred_target,
  output logic             mispredict,
  output logic [31:0]      branch_cnt,
  output logic [31:0]      mispred_cnt,
  input  logic [IDX_W-1:0] dbg_idx,
  output logic [31:0]      dbg_entry
);

  localparam int unsigned TAG_W = XLEN - IDX_W - 2;

  localparam logic [CTR_W-1:0] CTR_WEAK_T  = CTR_W'(weak_taken(CTR_W));
  localparam logic [CTR_W-1:0] CTR_WEAK_NT = CTR_W'(weak_not_taken(CTR_W));
  localparam logic [31:0]      STAT_MAX    = 32'hFFFF_FFFF;

  // Entry layout matches bp_entry_t, sized for this instance's geometry.
  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [CTR_W-1:0] ctr;
    logic [XLEN-1:0]  target;
  } entry_t;

  // Flop array: the lookup must be readable combinationally.
  entry_t      r_tab [ENTRIES];
  logic [31:0] r_branch_cnt;
  logic [31:0] r_mispred_cnt;

  logic [IDX_W-1:0] w_if_idx;
  logic [TAG_W-1:0] w_if_tag;
  logic             w_if_hit;
  logic [IDX_W-1:0] w_ex_idx;
  logic [TAG_W-1:0] w_ex_tag;
  logic             w_ex_tag_eq;
  logic             w_ex_hit;
  logic             w_br_valid;
  logic             w_ctr_inc;
  logic             w_ctr_dec;
  logic             w_ctr_load;
  logic [CTR_W-1:0] w_ctr_next;

  // Fetch-side lookup.
  assign w_if_idx = IDX_W'(idx_of(BP_PC_MAX'(if_pc), IDX_W));
  assign w_if_tag = TAG_W'(tag_of(BP_PC_MAX'(if_pc), IDX_W));
  assign w_if_hit = r_tab[w_if_idx].valid && (r_tab[w_if_idx].tag == w_if_tag);

  assign pred_taken  = w_if_hit && r_tab[w_if_idx].ctr[CTR_W-1];
  assign pred_target = pred_taken ? r_tab[w_if_idx].target : (if_pc + XLEN'(4));

  // Misprediction detect from the carried prediction and the resolved outcome.
  always_comb begin
    mispredict = 1'b0;
    if (ex_valid) begin
      if (ex_is_branch) begin
        mispredict = (ex_pred_taken != ex_taken) ||
                     (ex_taken && (ex_pred_target != ex_target));
      end else begin
        mispredict = ex_pred_taken;
      end
    end
  end

  // EX-side lookup for training.
  assign w_ex_idx    = IDX_W'(idx_of(BP_PC_MAX'(ex_pc), IDX_W));
  assign w_ex_tag    = TAG_W'(tag_of(BP_PC_MAX'(ex_pc), IDX_W));
  assign w_ex_tag_eq = (r_tab[w_ex_idx].tag == w_ex_tag);
  assign w_ex_hit    = r_tab[w_ex_idx].valid && w_ex_tag_eq;
  assign w_br_valid  = ex_valid && ex_is_branch;

  assign w_ctr_inc  = w_br_valid && w_ex_hit && ex_taken;
  assign w_ctr_dec  = w_br_valid && w_ex_hit && !ex_taken;
  assign w_ctr_load = w_br_valid && !w_ex_hit && ex_taken;

  // Only one entry trains per cycle, so a single counter datapath suffices.
  sat_counter #(
    .CTR_W (CTR_W)
  ) u_sat_counter (
    .i_ctr      (r_tab[w_ex_idx].ctr),
    .inc        (w_ctr_inc),
    .dec        (w_ctr_dec),
    .load       (w_ctr_load),
    .i_load_val (CTR_WEAK_T),
    .o_next_c   (w_ctr_next)
  );

  // Table training and statistics; reset wins over a same-cycle EX update.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        r_tab[i] <= '{valid: 1'b0, tag: '0, ctr: CTR_WEAK_NT, target: '0};
      end
      r_branch_cnt  <= '0;
      r_mispred_cnt <= '0;
    end else if (ex_valid) begin
      if (ex_is_branch) begin
        if (w_ex_hit) begin
          r_tab[w_ex_idx].ctr <= w_ctr_next;
          if (ex_taken) r_tab[w_ex_idx].target <= ex_target;
        end else if (ex_taken) begin
          // Allocate, evicting whatever aliased into this slot.
          r_tab[w_ex_idx] <= '{valid: 1'b1, tag: w_ex_tag, ctr: w_ctr_next, target: ex_target};
        end
        if (r_branch_cnt != STAT_MAX) r_branch_cnt <= r_branch_cnt + 32'd1;
      end else if (ex_pred_taken && w_ex_tag_eq) begin
        // A non-branch was predicted taken: drop the stale entry it aliased.
        r_tab[w_ex_idx].valid <= 1'b0;
      end
      if (mispredict && (r_mispred_cnt != STAT_MAX)) r_mispred_cnt <= r_mispred_cnt + 32'd1;
    end
  end

  assign branch_cnt  = r_branch_cnt;
  assign mispred_cnt = r_mispred_cnt;

  // Debug view: valid in bit 31, counter in the low bits, zeros elsewhere.
  always_comb begin
    dbg_entry              = '0;
    dbg_entry[31]          = r_tab[dbg_idx].valid;
    dbg_entry[CTR_W-1:0]   = r_tab[dbg_idx].ctr;
  end

endmodule

// File: tb/tb_bht_predictor.sv
// Self-checking bench for bht_predictor: directed scenarios followed by random
// traffic, compared against an entry-array reference model.
module tb_bht_predictor;
  import bp_pkg::*;

  localparam int unsigned NE = BP_ENTRIES;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        ex_is_branch;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        mispredict;
  logic [31:0] branch_cnt;
  logic [31:0] mispred_cnt;
  logic [3:0]  dbg_idx;
  logic [31:0] dbg_entry;

  int n_checks = 0;
  int n_errors = 0;

  bp_entry_t   m_tab [NE];
  logic [31:0] m_bcnt;
  logic [31:0] m_mcnt;

  bht_predictor #(.ENTRIES(16), .CTR_W(2), .XLEN(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .if_pc          (if_pc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .ex_valid       (ex_valid),
    .ex_pc          (ex_pc),
    .ex_is_branch   (ex_is_branch),
    .ex_taken       (ex_taken),
    .ex_target      (ex_target),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .mispredict     (mispredict),
    .branch_cnt     (branch_cnt),
    .mispred_cnt    (mispred_cnt),
    .dbg_idx        (dbg_idx),
    .dbg_entry      (dbg_entry)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned m_idx(input logic [31:0] pc);
    return int'((pc / 4) % NE);
  endfunction

  function automatic logic [BP_TAG_W-1:0] m_tag(input logic [31:0] pc);
    return BP_TAG_W'(pc / (4 * NE));
  endfunction

  function automatic void model_lookup(input logic [31:0] pc, output logic tk, output logic [31:0] tg);
    bp_entry_t ent;
    ent = m_tab[m_idx(pc)];
    tk  = ent.valid && (ent.tag == m_tag(pc)) && (ent.ctr >= 2'd2);
    tg  = tk ? ent.target : pc + 32'd4;
  endfunction

  function automatic logic model_mispredict();
    if (!ex_valid) return 1'b0;
    if (ex_is_branch) return (ex_pred_taken != ex_taken) || (ex_taken && ex_pred_target != ex_target);
    return ex_pred_taken;
  endfunction

  // Applies what the clock edge does to the reference state.
  task automatic model_edge();
    int unsigned e;
    logic [BP_TAG_W-1:0] t;
    logic hit, mp;
    if (rst) begin
      for (int i = 0; i < NE; i++) m_tab[i] = '{valid: 1'b0, tag: '0, ctr: 2'd1, target: '0};
      m_bcnt = 0;
      m_mcnt = 0;
      return;
    end
    if (!ex_valid) return;
    mp  = model_mispredict();
    e   = m_idx(ex_pc);
    t   = m_tag(ex_pc);
    hit = m_tab[e].valid && (m_tab[e].tag == t);
    if (ex_is_branch) begin
      if (m_bcnt != 32'hFFFF_FFFF) m_bcnt = m_bcnt + 1;
      if (hit) begin
        if (ex_taken) begin
          if (m_tab[e].ctr < 2'd3) m_tab[e].ctr = m_tab[e].ctr + 2'd1;
          m_tab[e].target = ex_target;
        end else if (m_tab[e].ctr > 2'd0) begin
          m_tab[e].ctr = m_tab[e].ctr - 2'd1;
        end
      end else if (ex_taken) begin
        m_tab[e] = '{valid: 1'b1, tag: t, ctr: 2'd2, target: ex_target};
      end
    end else if (ex_pred_taken && m_tab[e].tag == t) begin
      m_tab[e].valid = 1'b0;
    end
    if (mp && m_mcnt != 32'hFFFF_FFFF) m_mcnt = m_mcnt + 1;
  endtask

  // One clock: compare combinational outputs against the model, take the
  // edge, then compare the registered statistics.
  task automatic do_cycle(input bit chk);
    logic        tk;
    logic [31:0] tg;
    if (chk) begin
      model_lookup(if_pc, tk, tg);
      check("pred_taken", pred_taken, tk);
      check("pred_target", pred_target, tg);
      check("mispredict", mispredict, model_mispredict());
      check("dbg_entry", dbg_entry, {m_tab[dbg_idx].valid, 29'd0, m_tab[dbg_idx].ctr});
    end
    @(posedge clk);
    model_edge();
    #1;
    check("branch_cnt", branch_cnt, m_bcnt);
    check("mispred_cnt", mispred_cnt, m_mcnt);
  endtask

  task automatic set_ex(input logic v, input logic [31:0] pc, input logic br, input logic tk,
                        input logic [31:0] tg, input logic ptk, input logic [31:0] ptg);
    ex_valid = v; ex_pc = pc; ex_is_branch = br; ex_taken = tk;
    ex_target = tg; ex_pred_taken = ptk; ex_pred_target = ptg;
  endtask

  function automatic logic [31:0] pick_pc();
    case ($urandom_range(0, 6))
      0:       return 32'h100;
      1:       return 32'h140;
      2:       return 32'h180;
      3:       return 32'h104;
      4:       return 32'h3C0;
      5:       return 32'h204;
      default: return {$urandom_range(0, 4095), 2'b00};
    endcase
  endfunction

  initial begin
    logic        tk;
    logic [31:0] tg;

    // Reset
    rst = 1'b1; if_pc = 32'h100; dbg_idx = 4'd0;
    set_ex(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    do_cycle(1'b0);
    rst = 1'b0;
    #1;
    check("reset_pred_taken", pred_taken, 1'b0);
    check("reset_pred_target", pred_target, 32'h104);
    check("reset_branch_cnt", branch_cnt, 32'd0);
    check("reset_mispred_cnt", mispred_cnt, 32'd0);
    do_cycle(1'b1);

    // First taken branch allocates and mispredicts
    set_ex(1'b1, 32'h100, 1'b1, 1'b1, 32'h080, 1'b0, 32'h104);
    #1;
    check("alloc_mispredict", mispredict, 1'b1);
    do_cycle(1'b1);
    set_ex(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    check("alloc_pred_taken", pred_taken, 1'b1);
    check("alloc_pred_target", pred_target, 32'h080);
    check("alloc_mispred_cnt", mispred_cnt, 32'd1);
    do_cycle(1'b1);

    // Saturation: five taken, one not taken
    for (int i = 0; i < 5; i++) begin
      set_ex(1'b1, 32'h100, 1'b1, 1'b1, 32'h080, 1'b1, 32'h080);
      #1;
      do_cycle(1'b1);
    end
    set_ex(1'b1, 32'h100, 1'b1, 1'b0, 32'h104, 1'b1, 32'h080);
    #1;
    do_cycle(1'b1);
    set_ex(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    check("sat_dbg_entry", dbg_entry, 32'h8000_0002);
    check("sat_pred_taken", pred_taken, 1'b1);
    do_cycle(1'b1);

    // Wrong target
    set_ex(1'b1, 32'h100, 1'b1, 1'b1, 32'h0C0, 1'b1, 32'h080);
    #1;
    check("wrongtgt_mispredict", mispredict, 1'b1);
    do_cycle(1'b1);
    set_ex(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    check("wrongtgt_pred_target", pred_target, 32'h0C0);
    do_cycle(1'b1);

    // Non-branch predicted taken: alias cleanup
    set_ex(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0C0);
    #1;
    check("nonbr_mispredict", mispredict, 1'b1);
    do_cycle(1'b1);
    set_ex(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    check("nonbr_dbg_entry", dbg_entry, 32'h0000_0003);
    check("nonbr_pred_target", pred_target, 32'h104);
    check("nonbr_branch_cnt", branch_cnt, 32'd8);
    do_cycle(1'b1);

    // Alias eviction by a same-index taken branch
    set_ex(1'b1, 32'h100, 1'b1, 1'b1, 32'h080, 1'b0, 32'h104);
    #1;
    do_cycle(1'b1);
    set_ex(1'b1, 32'h140, 1'b1, 1'b1, 32'h200, 1'b0, 32'h144);
    #1;
    do_cycle(1'b1);
    set_ex(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    check("alias_pred_taken", pred_taken, 1'b0);
    check("alias_pred_target", pred_target, 32'h104);
    do_cycle(1'b1);

    // Same-index read and write: lookup sees the pre-update entry
    if_pc = 32'h140;
    set_ex(1'b1, 32'h140, 1'b1, 1'b0, 32'h144, 1'b1, 32'h200);
    #1;
    check("rw_pred_taken_pre", pred_taken, 1'b1);
    check("rw_pred_target_pre", pred_target, 32'h200);
    do_cycle(1'b1);
    set_ex(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    check("rw_pred_taken_post", pred_taken, 1'b0);
    do_cycle(1'b1);

    // Reset mid-operation with an EX update in the reset cycle
    rst = 1'b1; if_pc = 32'h180;
    set_ex(1'b1, 32'h180, 1'b1, 1'b1, 32'h300, 1'b0, 32'h184);
    #1;
    do_cycle(1'b1);
    rst = 1'b0;
    set_ex(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    check("rst_dbg_entry", dbg_entry, 32'h0000_0001);
    check("rst_pred_taken", pred_taken, 1'b0);
    check("rst_pred_target", pred_target, 32'h184);
    check("rst_branch_cnt", branch_cnt, 32'd0);
    check("rst_mispred_cnt", mispred_cnt, 32'd0);
    do_cycle(1'b1);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      rst     = ($urandom_range(0, 63) == 0);
      if_pc   = pick_pc();
      dbg_idx = 4'($urandom_range(0, 15));
      ex_valid      = ($urandom_range(0, 3) != 0);
      ex_pc         = pick_pc();
      ex_is_branch  = ($urandom_range(0, 4) != 0);
      ex_taken      = 1'($urandom);
      ex_target     = {$urandom_range(0, 255), 4'b0000};
      if ($urandom_range(0, 1) == 1) begin
        model_lookup(ex_pc, tk, tg);
        ex_pred_taken  = tk;
        ex_pred_target = tg;
      end else begin
        ex_pred_taken  = 1'($urandom);
        ex_pred_target = {$urandom_range(0, 255), 4'b0000};
      end
      #1;
      do_cycle(1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
